// File: rtl/stepmotor_pkg.sv
// Shared types and field layout for the stepper-motor sequence player.
package stepmotor_pkg;

    typedef enum logic [1:0] {
        OP_STEP = 2'b00,
        OP_WAIT = 2'b01,
        OP_JUMP = 2'b10,
        OP_HALT = 2'b11
    } op_t;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 30;
    localparam int DIR_BIT = 29;
    localparam int ARG_MSB = 28;
    localparam int ARG_LSB = 16;
    localparam int PER_MSB = 15;
    localparam int PER_LSB = 0;

    localparam int ARG_W   = ARG_MSB - ARG_LSB + 1;
    localparam int PER_W   = PER_MSB - PER_LSB + 1;
    localparam int TIMER_W = ARG_W + PER_W;

    typedef struct packed {
        op_t              op;
        logic             dir;
        logic [ARG_W-1:0] arg;
        logic [PER_W-1:0] period;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_EXEC,
        ST_STEP,
        ST_DELAY
    } state_t;

    localparam logic [3:0] PHASE_RESET_DFLT = 4'b0001;

    function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p,
                                                      input logic [PER_W-1:0] lo);
        return (p < lo) ? lo : p;
    endfunction

endpackage

// File: rtl/stepmotor_phase_gen.sv
// Coil phase register; rotates the one-hot wave pattern one position per advance.
module stepmotor_phase_gen #(
    parameter logic [3:0] PHASE_RESET = 4'b0001
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       advance,
    input  logic       dir,
    output logic [3:0] phase
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            phase <= PHASE_RESET;
        else if (advance)
            phase <= dir ? {phase[2:0], phase[3]} : {phase[0], phase[3:1]};
    end

endmodule

// File: rtl/stepmotor_seq_player.sv
// Fetches step-command words from program RAM and plays them out on the stepper coils.
module stepmotor_seq_player
    import stepmotor_pkg::*;
#(
    parameter int         ADDR_W      = 13,
    parameter int         MIN_PERIOD  = 1,
    parameter logic [3:0] PHASE_RESET = PHASE_RESET_DFLT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    output logic [3:0]        phase,
    output logic              coil_en,
    output logic              busy,
    output logic              done,
    output logic [15:0]       steps_total
);

    localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PERIOD);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    cmd_t                cmd, cmd_nxt;
    logic [ARG_W-1:0]    remaining, remaining_nxt;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic [15:0]         steps_nxt;
    logic                done_nxt;
    logic                advance;
    logic [PER_W-1:0]    step_period;
    logic [TIMER_W-1:0]  wait_val;

    assign step_period  = clamp_period(cmd.period, MIN_P);
    assign wait_val     = {cmd.arg, cmd.period};

    assign m_address    = pc;
    assign m_chipselect = (state == ST_FETCH);
    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign coil_en      = (state == ST_STEP);
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            cmd         <= '0;
            remaining   <= '0;
            timer       <= '0;
            steps_total <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            cmd         <= cmd_nxt;
            remaining   <= remaining_nxt;
            timer       <= timer_nxt;
            steps_total <= steps_nxt;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        cmd_nxt       = cmd;
        remaining_nxt = remaining;
        timer_nxt     = timer;
        steps_nxt     = steps_total;
        done_nxt      = 1'b0;
        advance       = 1'b0;

        // stop beats everything, including a step edge due this cycle
        if (state != ST_IDLE && stop) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc_nxt    = start_addr;
                        steps_nxt = '0;
                        state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: state_nxt = ST_LATCH;
                ST_LATCH: begin
                    cmd_nxt.op     = op_t'(m_readdata[OP_MSB:OP_LSB]);
                    cmd_nxt.dir    = m_readdata[DIR_BIT];
                    cmd_nxt.arg    = m_readdata[ARG_MSB:ARG_LSB];
                    cmd_nxt.period = m_readdata[PER_MSB:PER_LSB];
                    pc_nxt         = pc + ADDR_W'(1);
                    state_nxt      = ST_EXEC;
                end
                ST_EXEC: begin
                    case (cmd.op)
                        OP_STEP: begin
                            if (cmd.arg == '0) begin
                                state_nxt = ST_FETCH;
                            end else begin
                                remaining_nxt = cmd.arg;
                                timer_nxt     = TIMER_W'(step_period);
                                state_nxt     = ST_STEP;
                            end
                        end
                        OP_WAIT: begin
                            timer_nxt = wait_val;
                            state_nxt = (wait_val == '0) ? ST_FETCH : ST_DELAY;
                        end
                        OP_JUMP: begin
                            pc_nxt    = ADDR_W'(cmd.arg);
                            state_nxt = ST_FETCH;
                        end
                        default: begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    endcase
                end
                ST_STEP: begin
                    if (timer == TIMER_W'(1)) begin
                        advance       = 1'b1;
                        steps_nxt     = (steps_total == 16'hFFFF) ? steps_total
                                                                  : steps_total + 16'd1;
                        remaining_nxt = remaining - ARG_W'(1);
                        if (remaining == ARG_W'(1))
                            state_nxt = ST_FETCH;
                        else
                            timer_nxt = TIMER_W'(step_period);
                    end else begin
                        timer_nxt = timer - TIMER_W'(1);
                    end
                end
                ST_DELAY: begin
                    if (timer == TIMER_W'(1))
                        state_nxt = ST_FETCH;
                    else
                        timer_nxt = timer - TIMER_W'(1);
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    stepmotor_phase_gen #(
        .PHASE_RESET (PHASE_RESET)
    ) u_phase_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (advance),
        .dir     (cmd.dir),
        .phase   (phase)
    );

endmodule

// File: tb/tb_stepmotor_seq_player.sv
// Directed bench for stepmotor_seq_player with a 1-cycle-latency RAM model.
module tb_stepmotor_seq_player;

    localparam logic [1:0] B_STEP = 2'b00;
    localparam logic [1:0] B_WAIT = 2'b01;
    localparam logic [1:0] B_JUMP = 2'b10;
    localparam logic [1:0] B_HALT = 2'b11;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [12:0] start_addr;
    logic [12:0] m_address;
    logic        m_chipselect;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata;
    logic [3:0]  phase;
    logic        coil_en;
    logic        busy;
    logic        done;
    logic [15:0] steps_total;

    logic [31:0] mem [0:8191];
    logic [12:0] ram_q;

    int n_chk = 0;
    int n_fail = 0;

    int         fetch_a[$];
    int         cs_double;
    logic       cs_prev;
    int         chg_k[$];
    logic [3:0] chg_v[$];
    int         n_coil, n_done, done_k;

    stepmotor_seq_player dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .start_addr   (start_addr),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_readdata   (m_readdata),
        .phase        (phase),
        .coil_en      (coil_en),
        .busy         (busy),
        .done         (done),
        .steps_total  (steps_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM registers the address, data comes out combinationally
    always @(posedge clk) if (m_chipselect) ram_q <= m_address;
    assign m_readdata = mem[ram_q];

    always @(negedge clk) begin
        if (m_chipselect) begin
            fetch_a.push_back(int'(m_address));
            if (cs_prev) cs_double <= cs_double + 1;
        end
        cs_prev <= m_chipselect;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [1:0] op, input logic dir,
                                       input logic [12:0] arg, input logic [15:0] per);
        return {op, dir, arg, per};
    endfunction

    function automatic int getk(input int i);
        return (i < chg_k.size()) ? chg_k[i] : -1;
    endfunction

    function automatic int getv(input int i);
        return (i < chg_v.size()) ? int'(chg_v[i]) : -1;
    endfunction

    function automatic int geta(input int i);
        return (i < fetch_a.size()) ? fetch_a[i] : -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; k counts clock edges after the one that samples start.
    task automatic run_prog(input string tag, input logic [12:0] sa, input int max_cyc);
        logic [3:0] ph_prev;
        chg_k.delete();
        chg_v.delete();
        fetch_a.delete();
        cs_double = 0;
        n_coil = 0;
        n_done = 0;
        done_k = -1;
        ph_prev = phase;
        start_addr = sa;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_on_start"}, 32'(busy), 1);
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (phase !== ph_prev) begin
                chg_k.push_back(k);
                chg_v.push_back(phase);
                ph_prev = phase;
            end
            if (coil_en) n_coil++;
            if (done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k > done_k) break;
        end
        chk({tag, "_done_seen"}, 32'(done_k >= 0), 1);
    endtask

    initial begin
        logic [3:0] ph_prev;
        int nchg;

        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        start_addr = '0;
        cs_double = 0;
        for (int i = 0; i < 8192; i++) mem[i] = mk(B_HALT, 1'b0, 13'd0, 16'd0);

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_address", 32'(m_address), 0);
        chk("rst_cs", 32'(m_chipselect), 0);
        chk("rst_phase", 32'(phase), 32'h1);
        chk("rst_coil", 32'(coil_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_steps", 32'(steps_total), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // forward 3 steps, period 4, then HALT
        mem[0] = mk(B_STEP, 1'b1, 13'd3, 16'd4);
        mem[1] = mk(B_HALT, 1'b0, 13'd0, 16'd0);
        run_prog("t1", 13'd0, 60);
        chk("t1_nchg", chg_k.size(), 3);
        chk("t1_k0", getk(0), 7);
        chk("t1_k1", getk(1), 11);
        chk("t1_k2", getk(2), 15);
        chk("t1_v0", getv(0), 32'h2);
        chk("t1_v1", getv(1), 32'h4);
        chk("t1_v2", getv(2), 32'h8);
        chk("t1_coil_cycles", n_coil, 12);
        chk("t1_steps", 32'(steps_total), 3);
        chk("t1_done_count", n_done, 1);
        chk("t1_done_k", done_k, 18);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_nfetch", fetch_a.size(), 2);
        chk("t1_fetch0", geta(0), 0);
        chk("t1_fetch1", geta(1), 1);
        chk("t1_cs_double", cs_double, 0);
        chk("t1_m_write", 32'(m_write), 0);
        chk("t1_byteen", 32'(m_byteenable), 32'hF);

        // reverse 2 steps at period 1 across address wrap
        do_reset();
        mem[8191] = mk(B_STEP, 1'b0, 13'd2, 16'd1);
        mem[0]    = mk(B_HALT, 1'b0, 13'd0, 16'd0);
        run_prog("t2", 13'd8191, 40);
        chk("t2_nchg", chg_k.size(), 2);
        chk("t2_k0", getk(0), 4);
        chk("t2_k1", getk(1), 5);
        chk("t2_v0", getv(0), 32'h8);
        chk("t2_v1", getv(1), 32'h4);
        chk("t2_steps", 32'(steps_total), 2);
        chk("t2_nfetch", fetch_a.size(), 2);
        chk("t2_fetch0", geta(0), 8191);
        chk("t2_fetch1", geta(1), 0);
        chk("t2_done_k", done_k, 8);

        // WAIT 10 cycles, JUMP over address 7, HALT at 9
        mem[5] = mk(B_WAIT, 1'b0, 13'd0, 16'd10);
        mem[6] = mk(B_JUMP, 1'b0, 13'd9, 16'd0);
        mem[7] = mk(B_STEP, 1'b1, 13'd5, 16'd2);
        mem[9] = mk(B_HALT, 1'b0, 13'd0, 16'd0);
        run_prog("t3", 13'd5, 60);
        chk("t3_coil_cycles", n_coil, 0);
        chk("t3_nchg", chg_k.size(), 0);
        chk("t3_done_k", done_k, 19);
        chk("t3_nfetch", fetch_a.size(), 3);
        chk("t3_fetch0", geta(0), 5);
        chk("t3_fetch1", geta(1), 6);
        chk("t3_fetch2", geta(2), 9);
        chk("t3_steps", 32'(steps_total), 0);

        // stop lands on a step edge; start while busy is ignored
        do_reset();
        mem[20] = mk(B_STEP, 1'b1, 13'd100, 16'd3);
        mem[21] = mk(B_HALT, 1'b0, 13'd0, 16'd0);
        fetch_a.delete();
        n_done = 0;
        nchg = 0;
        ph_prev = phase;
        start_addr = 13'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_addr = 13'd21;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (phase !== ph_prev) begin
                nchg++;
                ph_prev = phase;
            end
            if (done) n_done++;
            start = (k == 10);
        end
        chk("t4_coil_before_stop", 32'(coil_en), 1);
        chk("t4_done_before_stop", n_done, 0);
        stop = 1'b1;
        @(negedge clk);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_coil", 32'(coil_en), 0);
        chk("t4_phase", 32'(phase), 32'h2);
        chk("t4_nchg", nchg, 5);
        chk("t4_steps", 32'(steps_total), 5);
        chk("t4_nfetch", fetch_a.size(), 1);
        stop = 1'b0;
        @(negedge clk);
        chk("t4_done_clear", 32'(done), 0);
        chk("t4_phase_hold", 32'(phase), 32'h2);
        chk("t4_idle", 32'(busy), 0);

        // asynchronous reset in the middle of a STEP command
        do_reset();
        mem[0] = mk(B_STEP, 1'b1, 13'd3, 16'd4);
        start_addr = 13'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("t5_pre_coil", 32'(coil_en), 1);
        chk("t5_pre_steps", 32'(steps_total), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_phase", 32'(phase), 32'h1);
        chk("t5_rst_coil", 32'(coil_en), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_steps", 32'(steps_total), 0);
        chk("t5_rst_cs", 32'(m_chipselect), 0);
        chk("t5_rst_addr", 32'(m_address), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_prog("t5", 13'd0, 60);
        chk("t5_steps", 32'(steps_total), 3);
        chk("t5_v2", getv(2), 32'h8);
        chk("t5_done_k", done_k, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
